// File: rtl/pam4_pkg.sv
// Shared PAM4 definitions for the TX encoder and RX decoder: symbol width,
// Gray map in both directions, PAM4 level names and the TX pairing states.
package pam4_pkg;

    localparam int SYM_W = 2;

    typedef logic [SYM_W-1:0] sym_t;

    // Levels are named by amplitude; the encoding is the Gray code on the wire.
    typedef enum logic [SYM_W-1:0] {
        LVL_M3 = 2'b00,
        LVL_M1 = 2'b01,
        LVL_P1 = 2'b11,
        LVL_P3 = 2'b10
    } pam4_lvl_e;

    typedef enum logic [1:0] {
        PAIR_EMPTY,
        PAIR_HALF,
        PAIR_FLUSH_WAIT
    } pair_state_e;

    function automatic sym_t gray_encode(input sym_t bin);
        return {bin[1], bin[1] ^ bin[0]};
    endfunction

    function automatic sym_t gray_decode(input sym_t gray);
        return {gray[1], gray[1] ^ gray[0]};
    endfunction

    function automatic pam4_lvl_e sym_to_level(input sym_t gray);
        return pam4_lvl_e'(gray);
    endfunction

endpackage

// File: rtl/gray_encode_tx_if.sv
// Bit-input and symbol-output handshake bundle of the PAM4 Gray encoder.
// The encoder is the slave; its stimulus/consumer side is the master.
interface gray_encode_tx_if
    import pam4_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic               bit_in;
    logic               bit_in_valid;
    logic               bit_in_ready;
    logic               flush;
    sym_t               symbol_out;
    logic               symbol_out_valid;
    logic               symbol_out_ready;
    logic               half_pending;
    logic [LEVEL_W-1:0] fifo_level;
    logic [31:0]        symbol_count;

    modport master (
        output bit_in, bit_in_valid, flush, symbol_out_ready,
        input  bit_in_ready, symbol_out, symbol_out_valid,
               half_pending, fifo_level, symbol_count
    );

    modport slave (
        input  bit_in, bit_in_valid, flush, symbol_out_ready,
        output bit_in_ready, symbol_out, symbol_out_valid,
               half_pending, fifo_level, symbol_count
    );

endinterface

// File: rtl/gray_encode_tx_sym_fifo.sv
// Parameterized synchronous first-word-fall-through FIFO: the head entry is
// always visible on head; one push and one pop per cycle.
module sym_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A push at full is legal only when the same cycle frees the head.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: the storage is cleared too, so the fall-through head reads 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == LVL_W'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/gray_encode_tx.sv
// TX-side PAM4 Gray encoder: pairs serial bits MSB-first, Gray-maps each pair
// and queues the symbols for the serializer behind a valid/ready handshake.
module gray_encode_tx
    import pam4_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit PAD_BIT    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    gray_encode_tx_if.slave  bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    pair_state_e      state;
    pair_state_e      state_nxt;
    logic             msb_q;
    logic             rst_q;
    logic [31:0]      sym_cnt;

    logic             ready;
    logic             accept;
    logic             room;
    logic             push;
    sym_t             push_data;
    logic             pop;
    sym_t             head;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level;

    // Room counts a slot freed by a pop in the same cycle.
    assign pop    = !empty && bus.symbol_out_ready;
    assign room   = !full || pop;
    assign accept = bus.bit_in_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PAIR_EMPTY;
            msb_q   <= 1'b0;
            rst_q   <= 1'b1;
            sym_cnt <= '0;
        end else begin
            state <= state_nxt;
            rst_q <= 1'b0;
            if (state == PAIR_EMPTY && accept) begin
                msb_q <= bus.bit_in;
            end
            if (push) begin
                sym_cnt <= sym_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PAIR_EMPTY: begin
                if (accept) state_nxt = PAIR_HALF;
            end
            PAIR_HALF: begin
                if (accept)         state_nxt = PAIR_EMPTY;
                else if (bus.flush) state_nxt = room ? PAIR_EMPTY : PAIR_FLUSH_WAIT;
            end
            PAIR_FLUSH_WAIT: begin
                if (room) state_nxt = PAIR_EMPTY;
            end
            default: state_nxt = PAIR_EMPTY;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        ready     = 1'b0;
        push      = 1'b0;
        push_data = gray_encode({msb_q, PAD_BIT});
        case (state)
            PAIR_EMPTY: begin
                ready = !rst_q;
            end
            PAIR_HALF: begin
                ready = !rst_q && room;
                if (accept) begin
                    push      = 1'b1;
                    push_data = gray_encode({msb_q, bus.bit_in});
                end else if (bus.flush && room) begin
                    push = 1'b1;
                end
            end
            PAIR_FLUSH_WAIT: begin
                push = room;
            end
            default: ;
        endcase
    end

    sym_fifo #(
        .WIDTH (SYM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign bus.bit_in_ready     = ready;
    assign bus.symbol_out       = head;
    assign bus.symbol_out_valid = !empty;
    assign bus.half_pending     = (state != PAIR_EMPTY);
    assign bus.fifo_level       = level;
    assign bus.symbol_count     = sym_cnt;

endmodule

// File: doc/gray_encode_tx.md
Name: gray_encode_tx

Overview:
- TX-side PAM4 Gray encoder. It is the counterpart to the RX Gray decoder.
- It accepts a serial bit stream, pairs consecutive bits into a 2-bit binary symbol, and Gray-maps each symbol.
- Encoded symbols are buffered in a small FIFO and presented to the downstream channel/serializer with a valid/ready handshake.
- Bit order matches the RX decoder exactly: the first bit of each pair is the binary MSB. The decoder emits the MSB first, so the round trip is lossless.

Parameters:
- FIFO_DEPTH, 4, number of symbol FIFO entries. Power of 2, at least 2.
- PAD_BIT, 0, value used to complete a half pair on flush.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- bit_in  in  1  serial data bit
- bit_in_valid  in  1  bit_in is valid this cycle
- bit_in_ready  out  1  encoder accepts a bit this cycle
- flush  in  1  single-cycle pulse: complete any pending half pair using PAD_BIT
- symbol_out  out  2  Gray-coded PAM4 symbol
- symbol_out_valid  out  1  symbol_out holds a valid symbol
- symbol_out_ready  in  1  downstream accepts the symbol
- half_pending  out  1  one bit is held, waiting for its partner
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current number of occupied FIFO entries
- symbol_count  out  32  total symbols pushed since reset; wraps modulo 2^32

Behaviour:
- Reset: synchronous; takes effect on any cycle where rst=1 at the clk edge. All outputs go to 0: bit_in_ready=0, symbol_out=0, symbol_out_valid=0, half_pending=0, fifo_level=0, symbol_count=0. Pair FSM goes to EMPTY and the FIFO pointers clear. A held half bit and all FIFO contents are discarded. Reset mid-stream gives no partial output.
- bit_in_ready = !rst_q && (fifo_level < FIFO_DEPTH || state==EMPTY). rst_q is a registered copy of rst, so ready stays 0 for the first cycle after reset is released. A first-of-pair bit is always accepted, since it only needs the MSB register. A second-of-pair bit requires a free FIFO slot; a free slot is also acceptable if the same cycle pops.
- Accept: a bit is accepted when bit_in_valid && bit_in_ready.
- Pair FSM, EMPTY: on accept, msb_q<=bit_in and go to HALF.
- Pair FSM, HALF: on accept, form b={msb_q,bit_in} and push the Gray code {b[1], b[1]^b[0]} to the FIFO, then go to EMPTY.
- Gray map, binary to Gray: 00->00, 01->01, 10->11, 11->10.
- half_pending=1 exactly while the FSM is in HALF.
- flush while in HALF with no accept in the same cycle: push {msb_q, msb_q^PAD_BIT} when the FIFO has room (including room freed by a pop in the same cycle), then go to EMPTY. If the FIFO is full, the flush stays pending internally and completes on the first cycle with room. While a flush is pending, bit_in_ready=0.
- flush while in EMPTY: no effect.
- flush in HALF coinciding with an accepted bit: the bit completes the pair normally and the flush is ignored.
- FIFO: at most one push and one pop per cycle. Pop on symbol_out_valid && symbol_out_ready. A simultaneous push and pop leaves the level unchanged and is legal at full or empty.
- FIFO output timing: output is first-word-fall-through. symbol_out/symbol_out_valid are driven from the head entry, so latency from accepting the second bit to symbol_out_valid=1 is 1 cycle.
- symbol_out while invalid: holds the last value; no requirement on its content.
- Output stability: while symbol_out_valid=1 && symbol_out_ready=0, symbol_out must not change.
- FIFO pointers: wrap modulo FIFO_DEPTH.
- symbol_count: increments on every push, including flush pushes.

Decomposition:
- Shared package pam4_pkg holds:
  - constants SYM_W=2
  - the Gray encode function and its inverse decode function, so TX and RX use one source of truth
  - PAM4 level enum LVL_M3/M1/P1/P3 mapped to Gray codes 00/01/11/10
- One sub-module is natural: sym_fifo. It is a parameterized synchronous FWFT FIFO with push, pop, full, empty and level, reusable elsewhere in the TX/RX datapath.

Test Plan:
- Bits 0,0,1,1,1,0,0,1 with symbol_out_ready=1 -> symbols 00,10,11,01 in that order, each valid 1 cycle after its second bit; symbol_count=4.
- Loopback through the RX Gray decoder with a PRBS7 stream of 254 bits -> decoded bit stream identical to the input; no dropped or duplicated bits.
- Hold symbol_out_ready=0 while sending 10 bits with FIFO_DEPTH=4:
  - 4 pushes complete; the 9th bit is accepted into HALF, then bit_in_ready=0 while HALF and full; the 10th bit stalls
  - fifo_level=4; symbol_out stays stable
  - release ready -> 5 symbols drain in order.
- Send bit 1, then pulse flush with PAD_BIT=0 -> one symbol 11 (binary 10); half_pending returns to 0.
- Flush with FIFO full and a pending half bit -> no push and bit_in_ready=0 until one pop; then the padded symbol is pushed on the pop cycle.
- Assert rst in HALF with 3 symbols queued -> next cycle all outputs are 0 and fifo_level=0; the following pair encodes correctly with no stale data.
